cci_mpf_shim_wro_addr_filter: RTL and testbench
===============================================

// Module: cci_mpf_shim_wro_addr_filter
// PURPOSE
//  Hashed line-address busy filter that feeds cci_mpf_shim_wro ordering decisions.
//  - The upstream WRO pipeline tests a hash for an in-flight conflict.
//  - It then inserts the hash on issue; the response path removes it on completion.
//  - Storage is a 2^HASH_BITS x 1 single-write-port RAM (one M20K at 14 bits).
//  - Inserts, removes and the post-reset clear sweep are arbitrated onto that one port.
// PARAMETERS
//  HASH_BITS          14  hash width; filter holds 2^HASH_BITS one-bit entries
//  REMOVE_FIFO_DEPTH  16  pending-remove queue depth, power of 2, >= 8
//  REMOVE_AF_SLACK     4  remove_almost_full asserts when count >= DEPTH-SLACK
// PORTS
//  clk                 in   1          single clock
//  reset_n             in   1          asynchronous, active-low reset
//  rdy                 out  1          clear sweep done; inputs honoured only while 1
//  test_en             in   1          lookup request this cycle
//  test_hash           in   HASH_BITS  hash to look up
//  test_rsp_valid      out  1          lookup result valid (test_en + 2 cycles)
//  test_busy           out  1          1 = hash has an outstanding insert
//  insert_en           in   1          mark hash busy
//  insert_hash         in   HASH_BITS  hash to mark
//  remove_en           in   1          clear hash (queued)
//  remove_hash         in   HASH_BITS  hash to clear
//  remove_almost_full  out  1          caller must stop issuing remove_en
//  overflow_err        out  1          sticky: remove_en while queue full
// BEHAVIOUR
//  Reset: async assert when reset_n=0; all state resets on assertion.
//   rdy=0, test_rsp_valid=0, test_busy=0, remove_almost_full=1, overflow_err=0.
//   Queue count=0, sweep index=0. RAM contents are undefined until the sweep runs.
//  FSM: INIT -> RUN.
//   INIT: write 0 at the sweep index each cycle, index+1.
//   After index 2^HASH_BITS-1 is written, go to RUN on the next edge.
//   rdy rises exactly 2^HASH_BITS cycles after the first edge with reset_n=1.
//   In INIT, test_en, insert_en and remove_en are ignored: no response, no enqueue.
//   RUN never returns to INIT except via reset_n.
//   Reset mid-operation aborts all pending work; in-flight tests produce no response.
//  Write port priority per cycle: INIT sweep > insert > remove-queue head.
//   Insert: writes 1 in the same cycle it is presented.
//   Remove: enqueued in its cycle; the head is written 0 on a cycle with no insert_en, then popped.
//   A remove_en in the same cycle as a pop is legal, so count stays constant.
//   Sustained insert_en every cycle starves removes.
//   The caller must honour remove_almost_full, which is asserted when count >= DEPTH-SLACK.
//  Overflow: remove_en with count==DEPTH drops that remove and sets overflow_err.
//   overflow_err clears only on reset.
//  Lookup: RAM read in cycle T with read-old-data semantics; data is registered in T+1.
//   test_rsp_valid and test_busy are driven in T+2; exactly one response per accepted test_en.
//   test_busy = RAM bit | (insert_en && insert_hash==test_hash in cycle T or T+1).
//   Guarantee: every insert presented in any cycle <= T+1 is visible to the test.
//   A remove is guaranteed visible only if its RAM write occurred at or before T-1.
//   Queued or just-written removes may still report busy. This false positive is the only permitted error.
//   A false "not busy" on a hash whose insert has not been removed is a bug.
//  Back-to-back test_en every cycle is legal; responses keep order, one per cycle.
//  Insert and remove of the same hash in the same cycle: the insert lands first.
//   The remove then clears the bit later; the caller must not do this unless the remove belongs to an older request.
//  Hash counting: the filter is a set, not a counter.
//   The caller must not insert a hash that is already busy (WRO stalls on test_busy).
// TESTING (HASH_BITS=4, REMOVE_FIFO_DEPTH=8, REMOVE_AF_SLACK=2 unless noted)
//  1. Release reset_n at edge 0 -> rdy=0 through edge 15, rdy=1 at edge 16.
//     test_en during INIT -> no test_rsp_valid.
//  2. insert 0x5, then test 0x5 one cycle later -> busy=1 at +2.
//     Test 0x6 -> busy=0. Insert 0x9 in the cycle after test 0x9 -> busy=1 (T+1 forward).
//  3. Insert 0x3, then remove 0x3 with no inserts, wait 3 cycles, test 0x3 -> busy=0.
//     Test issued the cycle after remove_en -> busy=1 is accepted.
//  4. Hold insert_en for 10 cycles while issuing 7 removes -> remove_almost_full=1 once count reaches 6.
//     Stop inserts -> queue drains one per cycle, almost_full drops at count 5.
//  5. Fill queue to 8 under constant inserts, issue one more remove -> overflow_err=1 and stays 1.
//     That remove is never applied; its bit stays busy.
//  6. Drop reset_n mid-drain with 3 tests in flight -> all outputs return to reset values within the cycle.
//     No stale test_rsp_valid; the full sweep repeats before rdy=1.

Source files
------------

// File: rtl/cci_mpf_shim_wro_addr_filter_if.sv
// Caller <-> filter signal bundle: lookup, insert, queued remove and status.
// Handshake: inputs are single-cycle strobes sampled on the rising edge, honoured only while rdy=1.
interface cci_mpf_shim_wro_addr_filter_if #(
    parameter int HASH_BITS = 14
);
    logic                 rdy;
    logic                 test_en;
    logic [HASH_BITS-1:0] test_hash;
    logic                 test_rsp_valid;
    logic                 test_busy;
    logic                 insert_en;
    logic [HASH_BITS-1:0] insert_hash;
    logic                 remove_en;
    logic [HASH_BITS-1:0] remove_hash;
    logic                 remove_almost_full;
    logic                 overflow_err;

    modport master (
        input  rdy, test_rsp_valid, test_busy, remove_almost_full, overflow_err,
        output test_en, test_hash, insert_en, insert_hash, remove_en, remove_hash
    );

    modport slave (
        output rdy, test_rsp_valid, test_busy, remove_almost_full, overflow_err,
        input  test_en, test_hash, insert_en, insert_hash, remove_en, remove_hash
    );
endinterface

// File: rtl/cci_mpf_shim_wro_addr_filter.sv
// Hashed line-address busy filter: 1-bit RAM with one write port shared by the
// post-reset clear sweep, inserts and a queue of pending removes.
module cci_mpf_shim_wro_addr_filter #(
    parameter int HASH_BITS         = 14,
    parameter int REMOVE_FIFO_DEPTH = 16,
    parameter int REMOVE_AF_SLACK   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    cci_mpf_shim_wro_addr_filter_if.slave bus,
    output logic                          dbg_state
);
    localparam int ENTRIES = 1 << HASH_BITS;
    localparam int PW      = $clog2(REMOVE_FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(REMOVE_FIFO_DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(REMOVE_FIFO_DEPTH - REMOVE_AF_SLACK);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [HASH_BITS:0]   sweep, sweep_nxt;
    logic                 we, wdata, push, pop, full, empty, rdy;
    logic [HASH_BITS-1:0] waddr;
    logic [CW-1:0]        count;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 mem [ENTRIES];
    logic [HASH_BITS-1:0] fifo [REMOVE_FIFO_DEPTH];
    logic                 rd_bit, s1_valid, s1_fwd, rsp_valid, rsp_busy, ovf;
    logic [HASH_BITS-1:0] s1_hash;

    assign rdy   = (state == RUN);
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // The extra sweep bit spends one cycle past the last write before RUN.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        we        = 1'b0;
        waddr     = bus.insert_hash;
        wdata     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            INIT: begin
                if (!sweep[HASH_BITS]) begin
                    we        = 1'b1;
                    waddr     = sweep[HASH_BITS-1:0];
                    sweep_nxt = sweep + (HASH_BITS+1)'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                push = bus.remove_en && !full;
                if (bus.insert_en) begin
                    we    = 1'b1;
                    waddr = bus.insert_hash;
                    wdata = 1'b1;
                end else if (!empty) begin
                    we    = 1'b1;
                    waddr = fifo[rd_ptr];
                    pop   = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (rdy && bus.remove_en && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.remove_hash;
    end

    // Read-old-data: a write on the same edge is covered by the forward terms.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_bit <= mem[bus.test_hash];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_fwd    <= 1'b0;
            s1_hash   <= '0;
            rsp_valid <= 1'b0;
            rsp_busy  <= 1'b0;
        end else begin
            s1_valid  <= rdy && bus.test_en;
            s1_fwd    <= rdy && bus.insert_en && (bus.insert_hash == bus.test_hash);
            s1_hash   <= bus.test_hash;
            rsp_valid <= s1_valid;
            rsp_busy  <= s1_valid && (rd_bit || s1_fwd ||
                         (bus.insert_en && (bus.insert_hash == s1_hash)));
        end
    end

    assign bus.rdy                = rdy;
    assign bus.test_rsp_valid     = rsp_valid;
    assign bus.test_busy          = rsp_busy;
    assign bus.remove_almost_full = !rdy || (count >= AF_CNT);
    assign bus.overflow_err       = ovf;
    assign dbg_state              = state;
endmodule

// File: tb/tb_cci_mpf_shim_wro_addr_filter.sv
// Directed + random bench for the WRO address filter against a cycle-level set model.
module tb_cci_mpf_shim_wro_addr_filter;
    localparam int HB = 4;
    localparam int D  = 8;
    localparam int S  = 2;
    localparam int N  = 1 << HB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dbg_state;

    cci_mpf_shim_wro_addr_filter_if #(.HASH_BITS(HB)) bus();

    cci_mpf_shim_wro_addr_filter #(
        .HASH_BITS(HB), .REMOVE_FIFO_DEPTH(D), .REMOVE_AF_SLACK(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: busy set as seen by the RAM, queue of pending removes,
    // and the two-cycle lookup latency as a pair of pending responses.
    bit bit_m [N];
    int rq [$];
    bit ovf_m, rdy_m;
    int n_edges;
    bit s1_v, s1_b, s2_v, s2_b;
    int s1_h;

    function automatic bit af_m();
        return !rdy_m || (rq.size() >= D - S);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        ovf_m = 0; rdy_m = 0; n_edges = 0;
        s1_v = 0; s1_b = 0; s2_v = 0; s2_b = 0; s1_h = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":rdy"}, bus.rdy, rdy_m);
        chk({where, ":state"}, dbg_state, rdy_m);
        chk({where, ":rsp_valid"}, bus.test_rsp_valid, s2_v);
        if (s2_v) chk({where, ":busy"}, bus.test_busy, s2_b);
        chk({where, ":almost_full"}, bus.remove_almost_full, af_m());
        chk({where, ":overflow"}, bus.overflow_err, ovf_m);
    endtask

    task automatic drive(input bit ti, input int th, input bit ii, input int ih,
                         input bit ri, input int rh);
        bus.test_en     = ti;
        bus.test_hash   = th[HB-1:0];
        bus.insert_en   = ii;
        bus.insert_hash = ih[HB-1:0];
        bus.remove_en   = ri;
        bus.remove_hash = rh[HB-1:0];
    endtask

    // One clock: model this cycle's inputs, take the edge, check #1 later.
    task automatic cycle(input string where);
        bit n1_v, n1_b, n2_v, n2_b;
        int n1_h, pre, th, ih, rh;
        n1_v = 0; n1_b = 0; n1_h = 0; n2_v = 0; n2_b = 0;
        th = int'(bus.test_hash); ih = int'(bus.insert_hash); rh = int'(bus.remove_hash);
        if (reset_n && rdy_m) begin
            n2_v = s1_v;
            n2_b = s1_b | (bus.insert_en && ih == s1_h);
            if (bus.test_en) begin
                n1_v = 1; n1_h = th;
                n1_b = bit_m[th] | (bus.insert_en && ih == th);
            end
            pre = rq.size();
            if (bus.insert_en) bit_m[ih] = 1;
            else if (pre > 0) bit_m[rq.pop_front()] = 0;
            if (bus.remove_en) begin
                if (pre == D) ovf_m = 1;
                else rq.push_back(rh);
            end
        end
        @(posedge clk);
        s2_v = n2_v; s2_b = n2_b; s1_v = n1_v; s1_b = n1_b; s1_h = n1_h;
        if (reset_n) begin
            n_edges++;
            if (!rdy_m && n_edges >= N + 1) begin
                rdy_m = 1;
                foreach (bit_m[i]) bit_m[i] = 0;
            end
        end
        #1;
        check_outputs(where);
    endtask

    task automatic rand_cycle(input string where);
        drive($urandom_range(0, 1), $urandom_range(0, N-1),
              $urandom_range(0, 3) == 0, $urandom_range(0, N-1),
              !af_m() && ($urandom_range(0, 1) == 1), $urandom_range(0, N-1));
        cycle(where);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outputs("reset");
        cycle("reset_hold");
        cycle("reset_hold");
        release_reset();

        // Sweep: random traffic must be ignored; rdy rises after N+1 edges
        for (int i = 0; i < N + 1; i++) rand_cycle("init");
        drive(0, 0, 0, 0, 0, 0);
        cycle("idle");
        cycle("idle");

        // Insert then test, miss, and next-cycle insert forwarding
        drive(0, 0, 1, 5, 0, 0); cycle("ins5");
        drive(1, 5, 0, 0, 0, 0); cycle("test5");
        drive(1, 6, 0, 0, 0, 0); cycle("test6");
        drive(1, 9, 0, 0, 0, 0); cycle("test9");
        drive(0, 0, 1, 9, 0, 0); cycle("ins9_fwd");
        drive(0, 0, 0, 0, 0, 0); cycle("idle"); cycle("idle");

        // Remove visibility
        drive(0, 0, 1, 3, 0, 0); cycle("ins3");
        drive(0, 0, 0, 0, 1, 3); cycle("rem3");
        drive(1, 3, 0, 0, 0, 0); cycle("test3_early");
        drive(0, 0, 0, 0, 0, 0); cycle("idle"); cycle("idle"); cycle("idle");
        drive(1, 3, 0, 0, 0, 0); cycle("test3_late");
        drive(0, 0, 0, 0, 0, 0); cycle("idle"); cycle("idle");

        // Inserts starve removes; almost_full at 6, drains once inserts stop
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 10, i < 7, i);
            cycle("starve");
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("drain");

        // Overflow: ninth remove under constant inserts is dropped
        drive(0, 0, 1, 12, 0, 0); cycle("ins12");
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 15, 1, (i == 8) ? 12 : i);
            cycle("fill");
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle("drain2");
        drive(1, 12, 0, 0, 0, 0); cycle("test12");
        drive(1, 0, 0, 0, 0, 0);  cycle("test0");
        drive(0, 0, 0, 0, 0, 0);  cycle("idle"); cycle("idle");

        for (int i = 0; i < 400; i++) rand_cycle("random");

        // Reset mid-drain with tests in flight
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, i + 1, 1, i + 1);
            cycle("prefill");
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 1, 0, 0, 0, 0);
            cycle("inflight");
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        drive(0, 0, 0, 0, 0, 0);
        cycle("reset_hold2");
        cycle("reset_hold2");
        release_reset();
        for (int i = 0; i < N + 1; i++) rand_cycle("init2");
        for (int i = 0; i < 60; i++) rand_cycle("random2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
